// File: rtl/mmp_iddmm_driver_if.sv
// Bundle of the driver's operand stream, core RAM/task port and result stream.
// master is the driver's view; slave is the surrounding environment's view.
interface mmp_iddmm_driver_if #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_mask;
  logic [K-1:0]      in_x;
  logic [K-1:0]      in_y;
  logic [K-1:0]      in_m;
  logic [K-1:0]      in_m1;
  logic [2:0]        mm_wr_ena;
  logic [ADDR_W-1:0] mm_wr_addr;
  logic [K-1:0]      mm_wr_x;
  logic [K-1:0]      mm_wr_y;
  logic [K-1:0]      mm_wr_m;
  logic [K-1:0]      mm_wr_m1;
  logic              mm_task_req;
  logic              mm_task_grant;
  logic [K-1:0]      mm_task_res;
  logic              mm_task_end;
  logic              out_valid;
  logic              out_ready;
  logic [K-1:0]      out_data;
  logic              out_last;
  logic              busy;
  logic              err;

  modport master (
    input  in_valid, in_mask, in_x, in_y, in_m, in_m1,
    input  mm_task_grant, mm_task_res, mm_task_end, out_ready,
    output in_ready, mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1,
    output mm_task_req, out_valid, out_data, out_last, busy, err
  );

  modport slave (
    output in_valid, in_mask, in_x, in_y, in_m, in_m1,
    output mm_task_grant, mm_task_res, mm_task_end, out_ready,
    input  in_ready, mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1,
    input  mm_task_req, out_valid, out_data, out_last, busy, err
  );
endinterface

// File: rtl/mmp_iddmm_driver.sv
// Host-side driver for the IDDMM core: loads operands, fires the task, buffers the result burst.
// Optional WAIT watchdog enabled by defining IDDMM_DRV_TIMEOUT_EN.
module mmp_iddmm_driver #(
  parameter int K           = 128,
  parameter int N           = 32,
  parameter int ADDR_W      = $clog2(N),
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  mmp_iddmm_driver_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_DRAIN} state_t;

  localparam logic [ADDR_W:0] N_CNT    = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   wcnt_reg, rcnt_reg, ocnt_reg;
  logic [2:0]        mask_reg;
  logic              over_reg;
  logic [2:0]        wr_ena_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [K-1:0]      wr_m1_reg;
  logic              req_reg;
  logic              err_reg, err_next;
  logic [K-1:0]      buf_mem [N];
  logic [K-1:0]      rd_data_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic              accept, grant_ok, out_fire, mismatch, tmo_expire;
  logic [2:0]        cur_mask;
  logic [ADDR_W:0]   grant_total;
  logic [K-1:0]      in_lane [3];

  assign accept      = bus.in_valid && (state_reg == S_LOAD);
  assign cur_mask    = (wcnt_reg == '0) ? bus.in_mask : mask_reg;
  assign grant_ok    = (state_reg == S_WAIT) && bus.mm_task_grant && (rcnt_reg != N_CNT);
  assign out_fire    = (state_reg == S_DRAIN) && bus.out_ready;
  assign grant_total = rcnt_reg + {{ADDR_W{1'b0}}, bus.mm_task_grant};
  // A grant arriving with rcnt already at N is an overflow even though total looks like N+1.
  assign mismatch    = over_reg || (grant_total != N_CNT);

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE:  state_next = S_LOAD;
      S_LOAD:  if (accept && wcnt_reg == LAST_IDX) state_next = S_REQ;
      S_REQ:   state_next = S_WAIT;
      S_WAIT: begin
        if (bus.mm_task_end) begin
          state_next = S_DRAIN;
          err_next   = mismatch;
        end else if (tmo_expire) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end
      end
      S_DRAIN: if (out_fire && ocnt_reg == LAST_IDX) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Read address runs one step ahead so the registered read lines up with ocnt.
  always_comb begin
    rd_addr = ocnt_reg[ADDR_W-1:0];
    if (state_reg != S_DRAIN) rd_addr = '0;
    else if (out_fire)        rd_addr = ocnt_reg[ADDR_W-1:0] + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      wcnt_reg    <= '0;
      rcnt_reg    <= '0;
      ocnt_reg    <= '0;
      over_reg    <= 1'b0;
      mask_reg    <= '0;
      wr_ena_reg  <= '0;
      wr_addr_reg <= '0;
      wr_m1_reg   <= '0;
      req_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      err_reg    <= err_next;
      req_reg    <= (state_reg == S_REQ);
      wr_ena_reg <= accept ? cur_mask : 3'b000;
      if (accept) begin
        wr_addr_reg <= wcnt_reg[ADDR_W-1:0];
        wcnt_reg    <= wcnt_reg + CNT_ONE;
        if (wcnt_reg == '0) begin
          mask_reg  <= bus.in_mask;
          wr_m1_reg <= bus.in_m1;
        end
      end
      if (state_reg == S_WAIT && bus.mm_task_grant) begin
        if (rcnt_reg == N_CNT) over_reg <= 1'b1;
        else                   rcnt_reg <= rcnt_reg + CNT_ONE;
      end
      if (out_fire) ocnt_reg <= ocnt_reg + CNT_ONE;
      if (state_reg == S_IDLE) begin
        wcnt_reg <= '0;
        rcnt_reg <= '0;
        ocnt_reg <= '0;
        over_reg <= 1'b0;
      end
    end
  end

  // Result buffer; bypass covers a final grant landing on the word being read.
  always_ff @(posedge clk) begin
    if (grant_ok) buf_mem[rcnt_reg[ADDR_W-1:0]] <= bus.mm_task_res;
    if (grant_ok && rcnt_reg[ADDR_W-1:0] == rd_addr) rd_data_reg <= bus.mm_task_res;
    else                                             rd_data_reg <= buf_mem[rd_addr];
  end

  assign in_lane[0] = bus.in_x;
  assign in_lane[1] = bus.in_y;
  assign in_lane[2] = bus.in_m;

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [K-1:0] data_reg;
    always_ff @(posedge clk) begin
      if (!rst_n)      data_reg <= '0;
      else if (accept) data_reg <= in_lane[gi];
    end
  end

`ifdef IDDMM_DRV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_reg;
  always_ff @(posedge clk) begin
    if (!rst_n || state_reg != S_WAIT) tmo_reg <= '0;
    else                               tmo_reg <= tmo_reg + TMO_W'(1);
  end
  assign tmo_expire = (state_reg == S_WAIT) && (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC != 0);
  assign tmo_expire = 1'b0;
`endif

  assign bus.in_ready    = (state_reg == S_LOAD);
  assign bus.mm_wr_ena   = wr_ena_reg;
  assign bus.mm_wr_addr  = wr_addr_reg;
  assign bus.mm_wr_x     = g_lane[0].data_reg;
  assign bus.mm_wr_y     = g_lane[1].data_reg;
  assign bus.mm_wr_m     = g_lane[2].data_reg;
  assign bus.mm_wr_m1    = wr_m1_reg;
  assign bus.mm_task_req = req_reg;
  assign bus.out_valid   = (state_reg == S_DRAIN);
  assign bus.out_data    = rd_data_reg;
  assign bus.out_last    = (state_reg == S_DRAIN) && (ocnt_reg == LAST_IDX);
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.err         = err_reg;
endmodule

// File: tb/tb_mmp_iddmm_driver.sv
// Self-checking bench for mmp_iddmm_driver: job table, write/result scoreboards, reset and timeout sequences.
module tb_mmp_iddmm_driver;
  localparam int K  = 128;
  localparam int N  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mmp_iddmm_driver_if #(.K(K), .N(N), .ADDR_W(AW)) bus ();
  mmp_iddmm_driver #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT_CYC(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0]   ena;
    logic [AW-1:0] addr;
    logic [K-1:0] x, y, m, m1;
  } wr_t;

  typedef struct {
    logic [2:0] mask;
    int         bubble;
    int         ngrants;
    int         delay;
    logic [3:0] rdy;
    int         exp_writes;
    int         exp_err;
  } job_t;

  wr_t          wr_q[$];
  wr_t          wr_e;
  logic [K-1:0] out_q[$];
  logic [K-1:0] model_buf [N];
  job_t         jobs [5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writes = 0;
  int err_pulses = 0;
  int last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Write-port scoreboard: every nonzero mm_wr_ena must match the next queued operand word.
  always @(negedge clk) begin
    if (bus.mm_wr_ena != 3'b000) begin
      writes++;
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got ena=%b addr=%0d, expected no write", bus.mm_wr_ena, bus.mm_wr_addr);
      end else begin
        wr_e = wr_q.pop_front();
        chk("wr_ena", K'(bus.mm_wr_ena), K'(wr_e.ena));
        chk("wr_addr", K'(bus.mm_wr_addr), K'(wr_e.addr));
        chk("wr_x", bus.mm_wr_x, wr_e.x);
        chk("wr_y", bus.mm_wr_y, wr_e.y);
        chk("wr_m", bus.mm_wr_m, wr_e.m);
        chk("wr_m1", bus.mm_wr_m1, wr_e.m1);
      end
    end
  end

  always @(negedge clk) if (bus.err) err_pulses++;

  task automatic chk_reset();
    chk("rst_ctl", K'({bus.in_ready, bus.mm_wr_ena, bus.mm_wr_addr, bus.mm_task_req,
                       bus.out_valid, bus.out_last, bus.busy, bus.err}), '0);
    chk("rst_wr_data", bus.mm_wr_x | bus.mm_wr_y | bus.mm_wr_m | bus.mm_wr_m1, '0);
  endtask

  task automatic load_job(input int j, input logic [2:0] mask, input int bubble,
                          input int nwords, input bit stray);
    int i = 0;
    int budget = 0;
    logic [K-1:0] m1;
    wr_t w;
    m1 = K'(32'hC0DE0000 + j);
    while (i < nwords && budget < 400) begin
      @(posedge clk); #1;
      budget++;
      bus.mm_task_grant = 1'b0;
      bus.mm_task_end   = 1'b0;
      if (stray && i == 5) begin
        bus.mm_task_grant = 1'b1;
        bus.mm_task_end   = 1'b1;
        bus.mm_task_res   = K'(32'hDEAD);
      end
      if (bubble != 0 && (budget % bubble) == 0) begin
        bus.in_valid = 1'b0;
      end else if (bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_x     = K'(j * 32'h1000 + i);
        bus.in_y     = K'(j * 32'h1000 + 32'h100 + i);
        bus.in_m     = K'(j * 32'h1000 + 32'h200 + i);
        bus.in_mask  = (i == 0) ? mask : ~mask;
        bus.in_m1    = (i == 0) ? m1 : ~m1;
        if (mask != 3'b000) begin
          w.ena = mask; w.addr = AW'(i);
          w.x = bus.in_x; w.y = bus.in_y; w.m = bus.in_m; w.m1 = m1;
          wr_q.push_back(w);
        end
        last_acc_cyc = cyc + 1;
        i++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.in_valid      = 1'b0;
    bus.mm_task_grant = 1'b0;
    bus.mm_task_end   = 1'b0;
    chk("load_words", K'(i), K'(nwords));
  endtask

  task automatic wait_req(output bit seen);
    int t = 0;
    @(posedge clk); #1;
    while (!bus.mm_task_req && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    seen = bus.mm_task_req;
    chk("req_seen", K'(bus.mm_task_req), K'(1));
  endtask

  task automatic run_job(input int j, input job_t jb);
    int w0 = writes;
    int e0 = err_pulses;
    int words = 0;
    int k = 0;
    int budget = 0;
    bit seen;
    bit have_held = 0;
    logic [K-1:0] held, exp_d, res;
    load_job(j, jb.mask, jb.bubble, N, j == 3);
    wait_req(seen);
    if (!seen) return;
    chk("writes", K'(writes - w0), K'(jb.exp_writes));
    chk("req_cycle", K'(cyc), K'(last_acc_cyc + 1));
    @(posedge clk); #1;
    chk("req_width", K'(bus.mm_task_req), K'(0));
    repeat (jb.delay) @(posedge clk);
    #1;
    for (int g = 0; g < jb.ngrants; g++) begin
      res = K'(32'hA000 + j * 32'h100 + g);
      bus.mm_task_grant = 1'b1;
      bus.mm_task_res   = res;
      bus.mm_task_end   = (g == jb.ngrants - 1);
      if (g < N) model_buf[g] = res;
      @(posedge clk); #1;
    end
    bus.mm_task_grant = 1'b0;
    bus.mm_task_end   = 1'b0;
    chk("first_valid", K'(bus.out_valid), K'(1));
    for (int i = 0; i < N; i++) out_q.push_back(model_buf[i]);
    while (words < N && budget < 200) begin
      bus.out_ready = jb.rdy[3 - (k % 4)];
      k++;
      budget++;
      chk("out_valid", K'(bus.out_valid), K'(1));
      if (bus.out_valid) begin
        if (have_held) chk("out_hold", bus.out_data, held);
        if (bus.out_ready) begin
          exp_d = out_q.pop_front();
          chk("out_data", bus.out_data, exp_d);
          chk("out_last", K'(bus.out_last), K'(words == N - 1));
          words++;
          have_held = 0;
        end else begin
          held = bus.out_data;
          have_held = 1;
        end
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    chk("drain_words", K'(words), K'(N));
    chk("err_pulses", K'(err_pulses - e0), K'(jb.exp_err));
    chk("done_busy", K'(bus.busy), K'(0));
    chk("done_valid", K'(bus.out_valid), K'(0));
    out_q.delete();
  endtask

  initial begin
    jobs[0] = '{mask: 3'b111, bubble: 0, ngrants: 32, delay: 2200, rdy: 4'b1111, exp_writes: 32, exp_err: 0};
    jobs[1] = '{mask: 3'b111, bubble: 5, ngrants: 32, delay: 10,   rdy: 4'b1001, exp_writes: 32, exp_err: 0};
    jobs[2] = '{mask: 3'b111, bubble: 0, ngrants: 31, delay: 10,   rdy: 4'b1111, exp_writes: 32, exp_err: 1};
    jobs[3] = '{mask: 3'b000, bubble: 0, ngrants: 32, delay: 5,    rdy: 4'b1111, exp_writes: 0,  exp_err: 0};
    jobs[4] = '{mask: 3'b101, bubble: 3, ngrants: 33, delay: 5,    rdy: 4'b1011, exp_writes: 32, exp_err: 1};
`ifdef IDDMM_DRV_TIMEOUT_EN
    jobs[0].delay = 20;
`endif
    for (int i = 0; i < N; i++) model_buf[i] = '0;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_mask = '0;
    bus.in_x = '0; bus.in_y = '0; bus.in_m = '0; bus.in_m1 = '0;
    bus.mm_task_grant = 1'b0; bus.mm_task_res = '0; bus.mm_task_end = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;

    // Reset in the middle of a load; next job must restart at address 0.
    load_job(9, 3'b111, 0, 10, 1'b0);
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_reset();
    end
    rst_n = 1'b1;
    wr_q.delete();

    for (int j = 0; j < 5; j++) begin
      run_job(j, jobs[j]);
      $display("job %0d: mask=%b grants=%0d checks=%0d errors=%0d", j, jobs[j].mask, jobs[j].ngrants, checks, errors);
    end

`ifdef IDDMM_DRV_TIMEOUT_EN
    begin
      bit seen;
      int rc, t;
      int e0;
      bit saw_valid = 0;
      e0 = err_pulses;
      load_job(5, 3'b111, 0, N, 1'b0);
      wait_req(seen);
      rc = cyc;
      t = 0;
      while (!bus.err && t < 200) begin
        @(posedge clk); #1;
        t++;
        if (bus.out_valid) saw_valid = 1;
      end
      chk("tmo_err", K'(bus.err), K'(1));
      chk("tmo_cycle", K'(cyc - rc), K'(64));
      chk("tmo_busy", K'(bus.busy), K'(0));
      @(posedge clk); #1;
      chk("tmo_err_width", K'(bus.err), K'(0));
      repeat (40) begin
        @(posedge clk); #1;
        if (bus.out_valid) saw_valid = 1;
      end
      chk("tmo_no_valid", K'(saw_valid), K'(0));
      chk("tmo_err_pulses", K'(err_pulses - e0), K'(1));
      $display("timeout: err after %0d cycles", cyc - rc);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmp_iddmm_driver.md
# mmp_iddmm_driver

Host-side driver for the IDDMM modular-multiplication core. Accepts operand words from an upstream valid/ready stream, writes them into the core's x/y/m RAMs through its write port, issues the task request, captures the N result words as the core emits them, and replays them downstream on a valid/ready stream. It sits between the Paillier/RSA sequencing logic and `mmp_iddmm_sp`, absorbing the core's non-backpressurable result burst.

## Interface
- `K`, 128, bits per word
- `N`, 32, words per operand
- `ADDR_W`, `$clog2(N)`, word address width
- `TIMEOUT_CYC`, 4096, watchdog limit in cycles; used only with `IDDMM_DRV_TIMEOUT_EN`

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operand word valid
- `in_ready`  out  1  operand word accepted when high with `in_valid`
- `in_mask`  in  3  per-job write enables {m,y,x}; sampled with word 0, held for the job
- `in_x`, `in_y`, `in_m`  in  K each  operand words, low word first
- `in_m1`  in  K  Montgomery constant; sampled with word 0
- `mm_wr_ena`  out  3  to core `wr_ena`
- `mm_wr_addr`  out  ADDR_W  to core `wr_addr`
- `mm_wr_x`, `mm_wr_y`, `mm_wr_m`, `mm_wr_m1`  out  K each  to core write data
- `mm_task_req`  out  1  to core `task_req`, single-cycle pulse
- `mm_task_grant`  in  1  core result word valid
- `mm_task_res`  in  K  core result word
- `mm_task_end`  in  1  core completion pulse
- `out_valid`  out  1  result word valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  K  result word, low word first
- `out_last`  out  1  high with word N-1
- `busy`  out  1  high in any state but IDLE
- `err`  out  1  single-cycle error pulse

## Operation
- States: IDLE, LOAD, REQ, WAIT, DRAIN.
- IDLE: `in_ready`=0. Moves to LOAD unconditionally next cycle (IDLE is a one-cycle settle after reset or job end).
- LOAD: `in_ready`=1. Each accepted word at counter `wcnt` is registered onto `mm_wr_*` next cycle with `mm_wr_ena = in_mask`, `mm_wr_addr = wcnt`; `mm_wr_m1` holds the word-0 sample. `in_mask`=3'b000 on word 0 still consumes N words but writes nothing. After word N-1 is accepted → REQ; `in_ready` drops the same cycle.
- REQ: one cycle; `mm_task_req` registered high in the following cycle, i.e. exactly one cycle after the last `mm_wr_ena`. → WAIT.
- WAIT: each `mm_task_grant` stores `mm_task_res` into buffer[`rcnt`], `rcnt`++. Grants beyond N are dropped and flag mismatch. On `mm_task_end` (including same cycle as the last grant, which is still stored) → DRAIN; if total grants ≠ N, `err` pulses on the transition.
- DRAIN: `out_data` = buffer[`ocnt`], `out_valid`=1, `out_last` = (`ocnt`==N-1). Advance on `out_valid & out_ready`. After the last handshake → IDLE. Always N words drained; unfilled entries carry stale data.
- Counters are ADDR_W+1 wide; no wrap within a job.
- `mm_wr_ena`=0 in every state except the cycle following an accepted LOAD word.

## Timing
- Reset values: `in_ready`=0, `mm_wr_ena`=0, `mm_wr_addr`=0, `mm_wr_x/y/m/m1`=0, `mm_task_req`=0, `out_valid`=0, `out_last`=0, `busy`=0, `err`=0. State=IDLE, all counters 0. Buffer contents not cleared.
- Reset mid-job: next cycle all outputs at reset values; the in-flight core task is abandoned (core outputs ignored until next `mm_task_req`).
- Load: N cycles minimum with `in_valid` held; bubbles allowed.
- First `out_valid`: 1 cycle after `mm_task_end`.
- Drain: N cycles minimum with `out_ready` held; `out_data`/`out_last` stable while `out_valid & !out_ready`.
- `mm_task_grant`/`mm_task_end` outside WAIT are ignored.

## Configuration
- `IDDMM_DRV_TIMEOUT_EN` defined: a counter starts at `mm_task_req`; if `mm_task_end` has not arrived after TIMEOUT_CYC cycles in WAIT, `err` pulses, state → IDLE, nothing is drained.
- Undefined: no counter; WAIT holds indefinitely; `err` signals only grant-count mismatch.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles mid-LOAD → all outputs 0, `busy`=0, next LOAD starts at `mm_wr_addr`=0.
- Load: stream x[i]=i, y[i]=0x100+i, m[i]=0x200+i, mask=3'b111 → 32 writes addr 0..31 with matching data, then `mm_task_req` 1 cycle after the write at addr 31, pulse width 1.
- Round trip with behavioural core (grants 2200 cycles after req, res[i]=0xA000+i, end with last grant) → out words 0xA000..0xA01F, `out_last` only on 0xA01F, `err`=0.
- Backpressure: `out_ready` toggled 1,0,0,1 → every word delivered exactly once, data held while stalled.
- Mismatch: core emits 31 grants then `mm_task_end` → `err` pulses once, 32 words still drained.
- With `IDDMM_DRV_TIMEOUT_EN`, TIMEOUT_CYC=64, core silent → `err` at cycle 64 after req, `busy` falls, `out_valid` never asserts.
